// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the prefetch queue and the issue register.
// Valid/ready: a transfer happens on a rising edge where valid and ready are
// both high and flush is low; ready never depends on valid, and the queue's
// ready/valid outputs come straight from registers.
interface fetch_queue_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          push_valid_fq_i;
   logic [AW-1:0] push_pc_fq_i;
   logic [AW-1:0] push_instr_fq_i;
   logic          push_ready_fq_o;
   logic          pop_valid_fq_o;
   logic [AW-1:0] pop_pc_fq_o;
   logic [AW-1:0] pop_instr_fq_o;
   logic          pop_ready_fq_i;
   logic          flush_fq_i;
   logic [CW-1:0] count_fq_o;

   // Queue side
   modport slave (
      input  push_valid_fq_i, push_pc_fq_i, push_instr_fq_i,
      input  pop_ready_fq_i, flush_fq_i,
      output push_ready_fq_o, pop_valid_fq_o, pop_pc_fq_o, pop_instr_fq_o,
      output count_fq_o
   );

   // Fetch / issue side
   modport master (
      output push_valid_fq_i, push_pc_fq_i, push_instr_fq_i,
      output pop_ready_fq_i, flush_fq_i,
      input  push_ready_fq_o, pop_valid_fq_o, pop_pc_fq_o, pop_instr_fq_o,
      input  count_fq_o
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: DEPTH-entry circular buffer of {PC+4, instr}
// with first-word fall-through head, registered ready/valid/count, and a
// flush that empties the queue at the edge that samples it.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   fetch_queue_if.slave  fq
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [AW-1:0] r_pc_mem    [DEPTH];
   logic [AW-1:0] r_instr_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_push_ready;
   logic w_pop_valid;
   logic w_push;
   logic w_pop;

   // Ready/valid come only from the count register; a full queue refuses a
   // push even when it is popping in the same cycle.
   assign w_push_ready = (r_count < CNT_FULL);
   assign w_pop_valid  = (r_count != '0);
   assign w_push = fq.push_valid_fq_i & w_push_ready & ~fq.flush_fq_i;
   assign w_pop  = w_pop_valid & fq.pop_ready_fq_i & ~fq.flush_fq_i;

   assign fq.push_ready_fq_o = w_push_ready;
   assign fq.pop_valid_fq_o  = w_pop_valid;
   assign fq.count_fq_o      = r_count;
   // Head is always driven from storage; consumers qualify with pop_valid.
   assign fq.pop_pc_fq_o     = r_pc_mem[r_rd_ptr];
   assign fq.pop_instr_fq_o  = r_instr_mem[r_rd_ptr];

   // Pointer, count and storage update; reset beats flush beats handshakes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pc_mem[i]    <= '0;
            r_instr_mem[i] <= '0;
         end
      end else if (fq.flush_fq_i) begin
         // Storage is left as is; only the bookkeeping is cleared.
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= fq.push_pc_fq_i;
            r_instr_mem[r_wr_ptr] <= fq.push_instr_fq_i;
            r_wr_ptr              <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: reset check, a vector table for fill/drain,
// hand-written multi-cycle corner sequences, then random traffic against a
// queue-based reference model.
module tb_fetch_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 32;

   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;

   fetch_queue_if #(.DEPTH(DEPTH), .AW(AW)) fq_if ();

   fetch_queue #(.DEPTH(DEPTH), .AW(AW)) u_dut (
      .clk   (clk),
      .reset (reset),
      .fq    (fq_if.slave)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pv;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        pr;
      logic        fl;
      logic [2:0]  e_cnt;
      logic        e_pv;
      logic        e_pr;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vecs[10];

   // Reference model: queue of {pc, instr}
   logic [63:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic pv, input logic [31:0] pc, input logic [31:0] instr,
                        input logic pr, input logic fl);
      fq_if.push_valid_fq_i = pv;
      fq_if.push_pc_fq_i    = pc;
      fq_if.push_instr_fq_i = instr;
      fq_if.pop_ready_fq_i  = pr;
      fq_if.flush_fq_i      = fl;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic push1(input logic [31:0] pc, input logic [31:0] instr);
      drive(1'b1, pc, instr, 1'b0, 1'b0);
      step();
      idle();
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b1;
      drive(1'b1, 32'h4, 32'h12345678, 1'b0, 1'b0);

      // Reset held 2 cycles with a push offered
      step();
      step();
      reset = 1'b0;
      idle();
      check("rst_count", 64'(fq_if.count_fq_o), 64'd0);
      check("rst_pop_valid", 64'(fq_if.pop_valid_fq_o), 64'd0);
      check("rst_push_ready", 64'(fq_if.push_ready_fq_o), 64'd1);
      check("rst_instr", 64'(fq_if.pop_instr_fq_o), 64'd0);
      check("rst_pc", 64'(fq_if.pop_pc_fq_o), 64'd0);
      step();
      check("rst_no_capture", 64'(fq_if.count_fq_o), 64'd0);

      // Fill to full, reject 5th, drain in order, pop on empty
      vecs[0] = '{1'b1, 32'h4,  32'h20080001, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h4,  32'h20080001};
      vecs[1] = '{1'b1, 32'h8,  32'h20080002, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h4,  32'h20080001};
      vecs[2] = '{1'b1, 32'hC,  32'h20080003, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h4,  32'h20080001};
      vecs[3] = '{1'b1, 32'h10, 32'h20080004, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 32'h4,  32'h20080001};
      vecs[4] = '{1'b1, 32'h14, 32'h20080005, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 32'h4,  32'h20080001};
      vecs[5] = '{1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 32'h8,  32'h20080002};
      vecs[6] = '{1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 32'hC,  32'h20080003};
      vecs[7] = '{1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 32'h10, 32'h20080004};
      vecs[8] = '{1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0,  32'h0};
      vecs[9] = '{1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0,  32'h0};
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].pv, vecs[i].pc, vecs[i].instr, vecs[i].pr, vecs[i].fl);
         step();
         check($sformatf("vec%0d_count", i), 64'(fq_if.count_fq_o), 64'(vecs[i].e_cnt));
         check($sformatf("vec%0d_pop_valid", i), 64'(fq_if.pop_valid_fq_o), 64'(vecs[i].e_pv));
         check($sformatf("vec%0d_push_ready", i), 64'(fq_if.push_ready_fq_o), 64'(vecs[i].e_pr));
         if (vecs[i].e_pv) begin
            check($sformatf("vec%0d_head_pc", i), 64'(fq_if.pop_pc_fq_o), 64'(vecs[i].e_pc));
            check($sformatf("vec%0d_head_instr", i), 64'(fq_if.pop_instr_fq_o), 64'(vecs[i].e_instr));
         end
      end
      idle();

      // Streaming wrap-around from count 1 (head 0xFF)
      push1(32'h3FC, 32'hFF);
      check("stream_start_count", 64'(fq_if.count_fq_o), 64'd1);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("stream%0d_head", i), 64'(fq_if.pop_instr_fq_o),
               (i == 0) ? 64'hFF : 64'(32'h100 + i - 1));
         drive(1'b1, 32'h400 + 32'(4 * i), 32'h100 + 32'(i), 1'b1, 1'b0);
         step();
         check($sformatf("stream%0d_count", i), 64'(fq_if.count_fq_o), 64'd1);
      end
      check("stream_last_head", 64'(fq_if.pop_instr_fq_o), 64'h109);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      idle();
      check("stream_drained", 64'(fq_if.count_fq_o), 64'd0);

      // Flush mid-stream with push and pop offered
      push1(32'h10, 32'hA1);
      push1(32'h14, 32'hA2);
      push1(32'h18, 32'hA3);
      check("flush_pre_count", 64'(fq_if.count_fq_o), 64'd3);
      drive(1'b1, 32'h1C, 32'hA4, 1'b1, 1'b1);
      step();
      idle();
      check("flush_count", 64'(fq_if.count_fq_o), 64'd0);
      check("flush_pop_valid", 64'(fq_if.pop_valid_fq_o), 64'd0);
      check("flush_push_ready", 64'(fq_if.push_ready_fq_o), 64'd1);
      push1(32'h8000, 32'hDEADBEEF);
      check("post_flush_valid", 64'(fq_if.pop_valid_fq_o), 64'd1);
      check("post_flush_count", 64'(fq_if.count_fq_o), 64'd1);
      check("post_flush_instr", 64'(fq_if.pop_instr_fq_o), 64'hDEADBEEF);
      check("post_flush_pc", 64'(fq_if.pop_pc_fq_o), 64'h8000);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step();
      idle();
      check("post_flush_drain", 64'(fq_if.count_fq_o), 64'd0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 4; i++) push1(32'h100 + 32'(4 * i), 32'h300 + 32'(i));
      check("full_count", 64'(fq_if.count_fq_o), 64'd4);
      drive(1'b1, 32'h200, 32'hAAAA0000, 1'b1, 1'b0);
      step();
      check("full_pp_count", 64'(fq_if.count_fq_o), 64'd3);
      check("full_pp_head", 64'(fq_if.pop_instr_fq_o), 64'h301);
      drive(1'b1, 32'h200, 32'hAAAA0000, 1'b0, 1'b0);
      step();
      check("retry_count", 64'(fq_if.count_fq_o), 64'd4);
      begin
         logic [31:0] exp_seq[4];
         exp_seq[0] = 32'h301;
         exp_seq[1] = 32'h302;
         exp_seq[2] = 32'h303;
         exp_seq[3] = 32'hAAAA0000;
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         for (int i = 0; i < 4; i++) begin
            check($sformatf("retry_drain%0d", i), 64'(fq_if.pop_instr_fq_o), 64'(exp_seq[i]));
            step();
         end
      end
      idle();
      check("retry_empty", 64'(fq_if.pop_valid_fq_o), 64'd0);

      // Reset mid-operation, together with flush and handshakes
      push1(32'h40, 32'hB1);
      push1(32'h44, 32'hB2);
      drive(1'b1, 32'h48, 32'hB3, 1'b1, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle();
      check("midrst_count", 64'(fq_if.count_fq_o), 64'd0);
      check("midrst_pop_valid", 64'(fq_if.pop_valid_fq_o), 64'd0);
      check("midrst_instr", 64'(fq_if.pop_instr_fq_o), 64'd0);

      // Random traffic against the reference model
      do_reset();
      exp_q.delete();
      for (int c = 0; c < 600; c++) begin
         logic        pv, pr, fl;
         logic [31:0] pc, instr;
         check("rnd_count", 64'(fq_if.count_fq_o), 64'(exp_q.size()));
         check("rnd_pop_valid", 64'(fq_if.pop_valid_fq_o), 64'(exp_q.size() != 0));
         check("rnd_push_ready", 64'(fq_if.push_ready_fq_o), 64'(exp_q.size() < DEPTH));
         if (exp_q.size() != 0)
            check("rnd_head", {fq_if.pop_pc_fq_o, fq_if.pop_instr_fq_o}, exp_q[0]);
         pv    = ($urandom_range(0, 9) < 7);
         pr    = ($urandom_range(0, 9) < 5);
         fl    = ($urandom_range(0, 19) == 0);
         pc    = $urandom & 32'hFFFF_FFFC;
         instr = $urandom;
         drive(pv, pc, instr, pr, fl);
         if (fl) begin
            exp_q.delete();
         end else begin
            bit can_push;
            can_push = pv && (exp_q.size() < DEPTH);
            if (pr && exp_q.size() != 0) void'(exp_q.pop_front());
            if (can_push) exp_q.push_back({pc, instr});
         end
         step();
      end
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the fetch stage (PC register, instruction memory, PC+4 adder) and the fetch/issue pipeline register. It buffers up to DEPTH fetched {PC+4, instruction} pairs so fetch keeps running while issue is stalled. It drains in program order to the issue register and discards all contents on a flush.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- AW, 32, width of the PC and instruction fields
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- push_valid_fq_i  in  1  fetch presents an entry
- push_pc_fq_i  in  AW  next sequential PC (PC+4) of the fetched instruction
- push_instr_fq_i  in  AW  fetched instruction word
- push_ready_fq_o  out  1  queue can accept an entry this cycle
- pop_valid_fq_o  out  1  head entry is valid
- pop_pc_fq_o  out  AW  head entry PC+4
- pop_instr_fq_o  out  AW  head entry instruction
- pop_ready_fq_i  in  1  issue register takes the head this cycle
- flush_fq_i  in  1  discard all entries (redirect or squash)
- count_fq_o  out  log2(DEPTH)+1  number of valid entries

## Operation
- Storage: DEPTH-entry circular buffer with a write pointer (wr_ptr) and a read pointer (rd_ptr), each log2(DEPTH) bits. Occupancy is held in a count register of log2(DEPTH)+1 bits.
- Push fires when push_valid_fq_i & push_ready_fq_o & ~flush_fq_i.
  - On a push, the entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop fires when pop_valid_fq_o & pop_ready_fq_i & ~flush_fq_i.
  - On a pop, rd_ptr increments modulo DEPTH.
- push_ready_fq_o = (count < DEPTH). It depends only on registered state, never on pop_ready_fq_i, so a full queue rejects a push even in a cycle where it pops.
- pop_valid_fq_o = (count != 0).
- pop_pc_fq_o and pop_instr_fq_o are the storage entry at rd_ptr (first-word fall-through). They are driven even when the queue is empty; the consumer must qualify them with pop_valid_fq_o.
- Count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop; legal whenever 0 < count < DEPTH
- Flush has priority over everything else.
  - Next cycle: count = 0, and wr_ptr = rd_ptr = 0.
  - Any push or pop offered in the flush cycle is dropped.
  - Storage contents are not cleared.
- There is no empty bypass: an entry pushed into an empty queue becomes visible at the head one cycle later.
- Order: entries leave strictly in push order across pointer wrap-around.
- Reset:
  - count, wr_ptr and rd_ptr go to 0, and all storage entries go to 0.
  - Outputs after reset: pop_valid_fq_o = 0, push_ready_fq_o = 1, pop_pc_fq_o = 0, pop_instr_fq_o = 0, count_fq_o = 0.
  - Reset overrides flush and handshakes in the same cycle. A reset asserted mid-operation discards all entries exactly like a flush.
- Fetch-side usage: hold the PC register when push_ready_fq_o = 0. Issue-side usage: hold the head when stalled by keeping pop_ready_fq_i low.

## Timing
- Latency from a push to that entry appearing at the head: 1 cycle when the queue was empty.
- Throughput: one push and one pop per cycle sustained when neither full nor empty.
- push_ready_fq_o, pop_valid_fq_o and count_fq_o are pure functions of registers; there is no combinational path from any input to them.
- pop_pc_fq_o and pop_instr_fq_o depend combinationally on rd_ptr and storage only.
- Flush takes effect at the edge that samples it. The cycle after a flush shows empty with push_ready_fq_o = 1.
- Boundary cases:
  - Full with pop: the pop is accepted, the push is not; count goes from DEPTH to DEPTH-1.
  - Empty with pop_ready_fq_i high: no pop, no state change.
  - Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.

## Test plan
- Reset then idle: assert reset for 2 cycles with push_valid_fq_i = 1.
  - After reset releases: count_fq_o = 0, pop_valid_fq_o = 0, push_ready_fq_o = 1, pop_instr_fq_o = 0.
  - No entry is captured during reset.
- Fill to full with pop_ready_fq_i = 0: push instructions 0x20080001..0x20080004 with PCs 0x4..0x10.
  - count_fq_o steps 1, 2, 3, 4.
  - push_ready_fq_o = 0 after the 4th push; a 5th push (0x20080005) is rejected and count stays 4.
- Drain in order: from full, raise pop_ready_fq_i.
  - pop_instr_fq_o reads 0x20080001, 0x20080002, 0x20080003, 0x20080004 on consecutive cycles.
  - pop_valid_fq_o drops in the cycle after the last pop; count reaches 0.
- Streaming wrap-around: push and pop every cycle for 10 cycles with instructions 0x100..0x109, starting from count = 1 (head 0xFF).
  - count stays 1.
  - Head sequence is 0xFF, 0x100, …, 0x108 with no gaps across pointer wrap.
- Flush mid-stream: with count = 3, assert flush_fq_i together with push_valid_fq_i = 1 and pop_ready_fq_i = 1.
  - Next cycle: count_fq_o = 0, pop_valid_fq_o = 0.
  - The pushed entry is lost. A subsequent push of 0xDEADBEEF appears at the head one cycle later with pop_pc_fq_o equal to its pushed PC.
- Full with simultaneous push and pop: at count = 4, push 0xAAAA0000 and pop in the same cycle.
  - Head advances; count becomes 3; 0xAAAA0000 is not stored.
  - The same push retried the next cycle is accepted; count returns to 4.
